pattern_event_counter: RTL and testbench

// - Sits directly downstream of the serial Mealy pattern detector and consumes its 2-bit hit vector
//   (bit0 = "111" seen, bit1 = "001" seen), sampled once per clock.
// - Counts hits of each pattern over a fixed window of WINDOW cycles.
// - At each window end, snapshots both counts into a one-deep output buffer with a valid/ready handshake.

---
 rtl/pattern_event_counter.sv | 183 ++++++++++++++++++
 tb/tb_pattern_event_counter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_event_counter.sv
// -----------------------------------------------------------------------------
// pattern_event_counter
//
// Purpose:
//   Counts the hits reported by the upstream serial pattern detector over a
//   fixed window of WINDOW clock cycles. hit[0] means "111" was seen and
//   hit[1] means "001" was seen. At the end of each window both counts are
//   captured into a one-deep output buffer. That buffer is read through a
//   valid/ready handshake.
//
// Parameters:
//   WINDOW  window length in clock cycles (>= 2)
//   CNT_W   width of each running counter and each snapshot field
//
// Ports:
//   clock      in   1      single clock, all state updates on posedge
//   reset      in   1      synchronous, active-high reset
//   hit        in   2      detector hit vector, sampled every cycle
//   out_ready  in   1      consumer ready
//   out_valid  out  1      snapshot pending in the output buffer
//   cnt_111    out  CNT_W  bit0 hit count of the last completed window
//   cnt_001    out  CNT_W  bit1 hit count of the last completed window
//   overrun    out  1      sticky: a window ended while a snapshot was pending
//
// Handshake:
//   A transfer happens on a posedge where out_valid && out_ready. out_valid
//   may rise without out_ready. While out_valid is high and no transfer
//   occurs, the snapshot fields hold, except when an overrun overwrites them.
//
// Configuration:
//   PEC_OVERWRITE_EN  defined   : on overrun the pending snapshot is replaced
//                                 by the new window's counts (newest wins)
//                     undefined : on overrun the new counts are dropped and
//                                 the pending snapshot is kept (oldest wins)
//
// Debug:
//   The output FSM state is held in state_q, of type state_t (EMPTY/FULL).
//   out_valid is a direct decode of that state.
// -----------------------------------------------------------------------------
module pattern_event_counter #(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       hit,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] cnt_111,
   output logic [CNT_W-1:0] cnt_001,
   output logic             overrun
);

   localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [TW-1:0]    TIMER_LAST = TW'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] run_111_q, run_111_d;
   logic [CNT_W-1:0] run_001_q, run_001_d;
   logic [CNT_W-1:0] snap_111_q, snap_111_d;
   logic [CNT_W-1:0] snap_001_q, snap_001_d;
   logic             overrun_q, overrun_d;

   logic             win_end;
   logic             transfer;
   logic             load_snap;
   logic [CNT_W-1:0] sum_111;
   logic [CNT_W-1:0] sum_001;

   // ---------------------------------------------------------------------------
   // Window timer and running counters
   // ---------------------------------------------------------------------------
   assign win_end  = (timer_q == TIMER_LAST);
   assign transfer = (state_q == FULL) && out_ready;

   // The count including this cycle's hit, saturating at CNT_MAX. At the end
   // of a window this value is the snapshot, so a hit in the last cycle
   // belongs to the window that is ending.
   always_comb begin
      sum_111 = run_111_q;
      sum_001 = run_001_q;
      if (hit[0] && (run_111_q != CNT_MAX)) begin
         sum_111 = run_111_q + CNT_W'(1);
      end
      if (hit[1] && (run_001_q != CNT_MAX)) begin
         sum_001 = run_001_q + CNT_W'(1);
      end
   end

   always_comb begin
      timer_d   = timer_q + TW'(1);
      run_111_d = sum_111;
      run_001_d = sum_001;
      if (win_end) begin
         timer_d   = '0;
         run_111_d = '0;
         run_001_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Output buffer FSM: next state and snapshot control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      overrun_d  = overrun_q;
      load_snap  = 1'b0;
      snap_111_d = snap_111_q;
      snap_001_d = snap_001_q;

      case (state_q)
         EMPTY: begin
            if (win_end) begin
               state_d   = FULL;
               load_snap = 1'b1;
            end
         end
         FULL: begin
            if (win_end) begin
               state_d = FULL;
               if (transfer) begin
                  // The old snapshot leaves on this edge and the new one
                  // takes its place, so nothing is lost.
                  load_snap = 1'b1;
               end else begin
                  overrun_d = 1'b1;
`ifdef PEC_OVERWRITE_EN
                  load_snap = 1'b1;
`else
                  load_snap = 1'b0;
`endif
               end
            end else if (transfer) begin
               state_d = EMPTY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      if (load_snap) begin
         snap_111_d = sum_111;
         snap_001_d = sum_001;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= EMPTY;
         timer_q    <= '0;
         run_111_q  <= '0;
         run_001_q  <= '0;
         snap_111_q <= '0;
         snap_001_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         run_111_q  <= run_111_d;
         run_001_q  <= run_001_d;
         snap_111_q <= snap_111_d;
         snap_001_q <= snap_001_d;
         overrun_q  <= overrun_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign cnt_111   = snap_111_q;
   assign cnt_001   = snap_001_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pattern_event_counter.sv
// -----------------------------------------------------------------------------
// tb_pattern_event_counter
//
// Purpose:
//   Self-checking bench for pattern_event_counter. It builds two instances:
//     - a main instance with WINDOW=8 and CNT_W=4
//     - a saturation instance with WINDOW=8 and CNT_W=3
//   A reference model tracks the main instance. The model keeps the hits of
//   the current window in a queue. When the queue holds WINDOW entries, it
//   sums the hits and saturates each sum. It then applies the one-deep buffer
//   rules.
//
//   The model follows the PEC_OVERWRITE_EN macro the same way the design does.
// -----------------------------------------------------------------------------
module tb_pattern_event_counter;

   localparam int WINDOW = 8;
   localparam int CNT_W  = 4;
   localparam int MAXV   = (1 << CNT_W) - 1;

   // clock / reset ---------------------------------------------------------
   logic clock;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // main instance ---------------------------------------------------------
   logic             reset;
   logic [1:0]       hit;
   logic             out_ready;
   logic             out_valid;
   logic [CNT_W-1:0] cnt_111;
   logic [CNT_W-1:0] cnt_001;
   logic             overrun;

   pattern_event_counter #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .hit       (hit),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .cnt_111   (cnt_111),
      .cnt_001   (cnt_001),
      .overrun   (overrun)
   );

   // saturation instance (CNT_W=3) -----------------------------------------
   logic       reset2;
   logic [1:0] hit2;
   logic       out_ready2;
   logic       out_valid2;
   logic [2:0] cnt2_111;
   logic [2:0] cnt2_001;
   logic       overrun2;

   pattern_event_counter #(.WINDOW(WINDOW), .CNT_W(3)) dut_sat (
      .clock     (clock),
      .reset     (reset2),
      .hit       (hit2),
      .out_ready (out_ready2),
      .out_valid (out_valid2),
      .cnt_111   (cnt2_111),
      .cnt_001   (cnt2_001),
      .overrun   (overrun2)
   );

   // counters --------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   // reference model -------------------------------------------------------
   logic [1:0] win_q[$];
   logic       m_valid;
   int         m_111;
   int         m_001;
   logic       m_ovr;

   // Advances the model by one clock edge, using the inputs sampled at it.
   task automatic model_edge(input logic [1:0] h, input logic rdy, input logic rst);
      int  s111;
      int  s001;
      logic xfer;
      if (rst) begin
         win_q.delete();
         m_valid = 1'b0;
         m_111   = 0;
         m_001   = 0;
         m_ovr   = 1'b0;
      end else begin
         xfer = m_valid && rdy;
         win_q.push_back(h);
         if (win_q.size() == WINDOW) begin
            s111 = 0;
            s001 = 0;
            foreach (win_q[i]) begin
               s111 += int'(win_q[i][0]);
               s001 += int'(win_q[i][1]);
            end
            if (s111 > MAXV) s111 = MAXV;
            if (s001 > MAXV) s001 = MAXV;
            win_q.delete();
            if (!m_valid || xfer) begin
               m_valid = 1'b1;
               m_111   = s111;
               m_001   = s001;
            end else begin
               m_ovr = 1'b1;
`ifdef PEC_OVERWRITE_EN
               m_111 = s111;
               m_001 = s001;
`endif
            end
         end else if (xfer) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // driver: applies one cycle of inputs, then samples 1 time unit after the edge
   task automatic tick(input logic [1:0] h, input logic rdy, input logic rst);
      hit       = h;
      out_ready = rdy;
      reset     = rst;
      @(posedge clock);
      model_edge(h, rdy, rst);
      #1;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(2'b11, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b0 || cnt_111 !== '0 || cnt_001 !== '0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: valid=%0b c111=%0d c001=%0d ovr=%0b, want all 0",
                     out_valid, cnt_111, cnt_001, overrun);
         end
      end
      tick(2'b00, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || cnt_111 !== '0 || cnt_001 !== '0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: valid=%0b c111=%0d c001=%0d ovr=%0b, want all 0",
                  out_valid, cnt_111, cnt_001, overrun);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_window_basic();
      logic [1:0] h;
      tick(2'b00, 1'b1, 1'b1);
      for (int c = 0; c < WINDOW; c++) begin
         h = 2'b00;
         if (c == 1 || c == 2 || c == 3) h = 2'b01;
         if (c == 5) h = 2'b10;
         tick(h, 1'b1, 1'b0);
         if (c < WINDOW - 1) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL basic_early_valid: cycle %0d valid=%0b want 0", c, out_valid);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || cnt_111 !== 4'd3 || cnt_001 !== 4'd1) begin
         errors++;
         $display("FAIL basic_snapshot: valid=%0b c111=%0d c001=%0d want 1/3/1",
                  out_valid, cnt_111, cnt_001);
      end
      tick(2'b00, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_one_cycle: valid=%0b want 0", out_valid);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_saturation();
      int snaps;
      snaps      = 0;
      hit2       = 2'b00;
      out_ready2 = 1'b1;
      reset2     = 1'b1;
      tick(2'b00, 1'b0, 1'b1);
      reset2 = 1'b0;
      hit2   = 2'b11;
      for (int c = 0; c < 3 * WINDOW; c++) begin
         tick(2'b00, 1'b0, 1'b1);
         if (out_valid2 === 1'b1) begin
            snaps++;
            checks++;
            if (cnt2_111 !== 3'd7 || cnt2_001 !== 3'd7) begin
               errors++;
               $display("FAIL sat_value: c111=%0d c001=%0d want 7/7", cnt2_111, cnt2_001);
            end
         end
      end
      checks++;
      if (snaps != 3 || overrun2 !== 1'b0) begin
         errors++;
         $display("FAIL sat_count: snapshots=%0d ovr=%0b want 3/0", snaps, overrun2);
      end
      reset2 = 1'b1;
      hit2   = 2'b00;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_overrun();
      int exp111;
`ifdef PEC_OVERWRITE_EN
      exp111 = 5;
`else
      exp111 = 2;
`endif
      tick(2'b00, 1'b0, 1'b1);
      for (int c = 0; c < WINDOW; c++) tick((c < 2) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || cnt_111 !== 4'd2 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_first: valid=%0b c111=%0d ovr=%0b want 1/2/0", out_valid, cnt_111, overrun);
      end
      for (int c = 0; c < WINDOW; c++) tick((c < 5) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || overrun !== 1'b1 || int'(cnt_111) != exp111 || cnt_001 !== 4'd0) begin
         errors++;
         $display("FAIL ovr_second: valid=%0b ovr=%0b c111=%0d c001=%0d want 1/1/%0d/0",
                  out_valid, overrun, cnt_111, cnt_001, exp111);
      end
      tick(2'b00, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_sticky: valid=%0b ovr=%0b want 0/1", out_valid, overrun);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_simul_transfer();
      logic [1:0] h;
      tick(2'b00, 1'b0, 1'b1);
      for (int c = 0; c < WINDOW; c++) tick((c < 3) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      for (int c = 0; c < WINDOW; c++) begin
         h = 2'b00;
         if (c == 0) h = 2'b10;
         if (c >= 1 && c <= 4) h = 2'b01;
         tick(h, (c == WINDOW - 1), 1'b0);
      end
      checks++;
      if (out_valid !== 1'b1 || cnt_111 !== 4'd4 || cnt_001 !== 4'd1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL simul_xfer: valid=%0b c111=%0d c001=%0d ovr=%0b want 1/4/1/0",
                  out_valid, cnt_111, cnt_001, overrun);
      end
      tick(2'b00, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || cnt_111 !== 4'd4 || cnt_001 !== 4'd1) begin
         errors++;
         $display("FAIL simul_hold: valid=%0b c111=%0d c001=%0d want 1/4/1",
                  out_valid, cnt_111, cnt_001);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_mid_reset();
      tick(2'b00, 1'b0, 1'b1);
      tick(2'b01, 1'b0, 1'b0);
      tick(2'b01, 1'b0, 1'b0);
      tick(2'b00, 1'b0, 1'b0);
      tick(2'b00, 1'b0, 1'b0);
      tick(2'b00, 1'b0, 1'b1);
      tick(2'b01, 1'b0, 1'b0);
      for (int c = 1; c < WINDOW; c++) begin
         tick(2'b00, 1'b0, 1'b0);
         if (c < WINDOW - 1) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL midrst_early: cycle %0d valid=%0b want 0", c, out_valid);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || cnt_111 !== 4'd1 || cnt_001 !== 4'd0) begin
         errors++;
         $display("FAIL midrst_snapshot: valid=%0b c111=%0d c001=%0d want 1/1/0",
                  out_valid, cnt_111, cnt_001);
      end
   endtask

   // -------------------------------------------------------------------------
   // Random traffic: random hits and ready, with occasional resets.
   // The outputs are compared with the model every cycle.
   task automatic test_random(input int n, input bit always_ready);
      logic [1:0] h;
      logic       r;
      logic       rs;
      tick(2'b00, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
         h  = 2'($urandom_range(0, 3));
         r  = always_ready ? 1'b1 : ($urandom_range(0, 3) == 0);
         rs = always_ready ? 1'b0 : ($urandom_range(0, 99) == 0);
         tick(h, r, rs);
         checks++;
         if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL rand_valid: cycle %0d got %0b want %0b", i, out_valid, m_valid);
         end
         checks++;
         if (int'(cnt_111) != m_111 || int'(cnt_001) != m_001) begin
            errors++;
            $display("FAIL rand_counts: cycle %0d got %0d/%0d want %0d/%0d",
                     i, cnt_111, cnt_001, m_111, m_001);
         end
         checks++;
         if (overrun !== m_ovr) begin
            errors++;
            $display("FAIL rand_overrun: cycle %0d got %0b want %0b", i, overrun, m_ovr);
         end
      end
   endtask

   // -------------------------------------------------------------------------
   initial begin
      reset      = 1'b1;
      hit        = 2'b00;
      out_ready  = 1'b0;
      reset2     = 1'b1;
      hit2       = 2'b00;
      out_ready2 = 1'b0;
      m_valid    = 1'b0;
      m_111      = 0;
      m_001      = 0;
      m_ovr      = 1'b0;

      test_reset();
      test_window_basic();
      test_saturation();
      test_overrun();
      test_simul_transfer();
      test_mid_reset();
      test_random(400, 1'b0);
      test_random(80, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
